// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor, LSB first, one borrow flop, Start/Busy/Done handshake.
// Optional signed-overflow output is enabled with `define SERIAL_SUB_OVERFLOW_EN.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_diff,
`ifdef SERIAL_SUB_OVERFLOW_EN
  output logic             o_overflow,
`endif
  output logic             o_borrow
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [CW-1:0]    r_cnt;
  logic             r_br;
`ifdef SERIAL_SUB_OVERFLOW_EN
  logic             r_a_msb;
  logic             r_b_msb;
`endif

  logic             w_a;
  logic             w_b;
  logic             w_d;
  logic             w_br_next;
  logic [WIDTH-1:0] w_acc_next;

  // Difference bits enter the vacated MSB of the minuend register, so after
  // WIDTH shifts r_sa holds the complete result (it doubles as the accumulator).
  assign w_a        = r_sa[0];
  assign w_b        = r_sb[0];
  assign w_d        = w_a ^ w_b ^ r_br;
  assign w_br_next  = (~w_a & w_b) | (~(w_a ^ w_b) & r_br);
  assign w_acc_next = {w_d, r_sa[WIDTH-1:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_sa       <= '0;
      r_sb       <= '0;
      r_cnt      <= '0;
      r_br       <= 1'b0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_diff     <= '0;
      o_borrow   <= 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
      r_a_msb    <= 1'b0;
      r_b_msb    <= 1'b0;
      o_overflow <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          o_done <= 1'b0;
          if (i_start) begin
            r_sa    <= i_a;
            r_sb    <= i_b;
            r_br    <= 1'b0;
            r_cnt   <= '0;
            o_busy  <= 1'b1;
            r_state <= S_SHIFT;
`ifdef SERIAL_SUB_OVERFLOW_EN
            r_a_msb <= i_a[WIDTH-1];
            r_b_msb <= i_b[WIDTH-1];
`endif
          end
        end
        S_SHIFT: begin
          r_sa <= w_acc_next;
          r_sb <= {1'b0, r_sb[WIDTH-1:1]};
          r_br <= w_br_next;
          if (r_cnt == LAST) begin
            o_diff   <= w_acc_next;
            o_borrow <= w_br_next;
            o_busy   <= 1'b0;
            o_done   <= 1'b1;
            r_state  <= S_DONE;
`ifdef SERIAL_SUB_OVERFLOW_EN
            o_overflow <= (r_a_msb ^ r_b_msb) & (w_d ^ r_a_msb);
`endif
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DONE: begin
          o_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          o_busy  <= 1'b0;
          o_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8): directed cases plus random
// operations against an arithmetic reference model; overflow checked when enabled.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow;
`ifdef SERIAL_SUB_OVERFLOW_EN
  logic         ovf;
  logic         ovf_prev;
`endif

  int n_chk = 0;
  int n_bad = 0;

  logic [W-1:0] diff_prev;
  logic         borrow_prev;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .i_start  (start),
    .i_a      (a),
    .i_b      (b),
    .o_busy   (busy),
    .o_done   (done),
    .o_diff   (diff),
`ifdef SERIAL_SUB_OVERFLOW_EN
    .o_overflow(ovf),
`endif
    .o_borrow (borrow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // mode 0: plain pulse; 1: stray Start with junk operands at edge 3;
  // 2: Start held high with junk operands through the whole operation.
  task automatic run_op(input logic [W-1:0] opa, input logic [W-1:0] opb, input int mode);
    logic [W-1:0] exp_diff;
    logic         exp_borrow;
    int           sd;
    exp_diff   = W'((32'(opa) + 32'd256 - 32'(opb)) % 256);
    exp_borrow = (opa < opb);
    sd = int'($signed(opa)) - int'($signed(opb));
    start = 1'b1; a = opa; b = opb;
    @(posedge clk); #1;
    chk("busy_e0", 32'(busy), 32'd1);
    chk("done_e0", 32'(done), 32'd0);
    start = (mode == 2); a = W'($urandom); b = W'($urandom);
    for (int e = 1; e <= W + 1; e++) begin
      @(posedge clk); #1;
      if (e < W) begin
        chk("busy_shift", 32'(busy), 32'd1);
        chk("done_shift", 32'(done), 32'd0);
        chk("diff_hold", 32'(diff), 32'(diff_prev));
        chk("borrow_hold", 32'(borrow), 32'(borrow_prev));
      end else if (e == W) begin
        chk("busy_cmp", 32'(busy), 32'd0);
        chk("done_cmp", 32'(done), 32'd1);
        chk("diff", 32'(diff), 32'(exp_diff));
        chk("borrow", 32'(borrow), 32'(exp_borrow));
`ifdef SERIAL_SUB_OVERFLOW_EN
        chk("overflow", 32'(ovf), ((sd > 127) || (sd < -128)) ? 32'd1 : 32'd0);
        ovf_prev = ((sd > 127) || (sd < -128));
`endif
      end else begin
        chk("done_after", 32'(done), 32'd0);
        chk("busy_after", 32'(busy), 32'd0);
        chk("diff_keep", 32'(diff), 32'(exp_diff));
      end
      if (mode == 1 && e == 2) begin
        start = 1'b1; a = W'($urandom); b = W'($urandom);
      end else if (mode == 1 && e == 3) begin
        start = 1'b0;
      end
    end
    diff_prev   = exp_diff;
    borrow_prev = exp_borrow;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    diff_prev = '0; borrow_prev = 1'b0;
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_diff", 32'(diff), 32'd0);
    chk("rst_borrow", 32'(borrow), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op(8'h35, 8'h12, 0);
    run_op(8'h12, 8'h35, 0);
    run_op(8'h00, 8'h01, 0);
    run_op(8'hAA, 8'hAA, 0);
    run_op(8'hFF, 8'h00, 0);
    run_op(8'h80, 8'h01, 0);
    run_op(8'h05, 8'h03, 0);
    run_op(8'h50, 8'h10, 1);
    run_op(8'h7F, 8'h80, 2);
    run_op(8'h01, 8'h02, 0);

    // Reset between edges 4 and 5 of an operation
    start = 1'b1; a = 8'h35; b = 8'h12;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_diff", 32'(diff), 32'd0);
    chk("abort_borrow", 32'(borrow), 32'd0);
`ifdef SERIAL_SUB_OVERFLOW_EN
    chk("abort_ovf", 32'(ovf), 32'd0);
`endif
    #1 rst = 1'b0;
    for (int e = 0; e < W + 3; e++) begin
      @(posedge clk); #1;
      chk("abort_no_done", 32'(done), 32'd0);
      chk("abort_idle", 32'(busy), 32'd0);
    end
    diff_prev = '0; borrow_prev = 1'b0;
    run_op(8'h35, 8'h12, 0);

    for (int i = 0; i < 40; i++)
      run_op(W'($urandom), W'($urandom), (i == 39) ? 0 : int'($urandom_range(0, 2)));
    start = 1'b0;
    @(posedge clk); #1;

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
